// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES envelope gates,
// stealing releasing or oldest active voices when no voice is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            note_valid,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note_num,
  output logic                            note_ready,
  output logic [NUM_VOICES-1:0]           voice_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  input  logic [NUM_VOICES-1:0]           voice_avail,
  output logic                            steal
);

  localparam int AGE_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    V_FREE,
    V_ACTIVE,
    V_RELEASING,
    V_RETRIG
  } vstate_t;

  logic [NUM_VOICES-1:0]            is_free;
  logic [NUM_VOICES-1:0]            is_active;
  logic [NUM_VOICES-1:0]            is_rel;
  logic [NUM_VOICES-1:0]            is_retrig;
  logic [NUM_VOICES-1:0]            note_hit;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;

  logic [NUM_VOICES-1:0] free_sel;
  logic [NUM_VOICES-1:0] rel_sel;
  logic [NUM_VOICES-1:0] act_sel;
  logic [NUM_VOICES-1:0] hit_sel;
  logic [NUM_VOICES-1:0] tgt_sel;
  logic [NUM_VOICES-1:0] off_sel;
  logic                  found_free;
  logic                  found_rel;
  logic                  found_act;
  logic                  found_hit;
  logic [AGE_W-1:0]      best_age;

  logic on_acc;
  logic off_acc;
  logic assign_en;
  logic steal_next;
  logic steal_reg;

  // A voice in its retrigger gap blocks new events for exactly one cycle.
  assign note_ready = ~(|is_retrig);
  assign on_acc     = note_valid & note_ready & note_on;
  assign off_acc    = note_valid & note_ready & ~note_on;
  assign assign_en  = on_acc & ~(|note_hit);

  // Priority pickers: lowest FREE, lowest RELEASING, oldest ACTIVE (ties to lowest), lowest match.
  always_comb begin
    free_sel   = '0;
    rel_sel    = '0;
    act_sel    = '0;
    hit_sel    = '0;
    found_free = 1'b0;
    found_rel  = 1'b0;
    found_act  = 1'b0;
    found_hit  = 1'b0;
    best_age   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (is_free[i] && !found_free) begin
        free_sel[i] = 1'b1;
        found_free  = 1'b1;
      end
      if (is_rel[i] && !found_rel) begin
        rel_sel[i] = 1'b1;
        found_rel  = 1'b1;
      end
      if (note_hit[i] && !found_hit) begin
        hit_sel[i] = 1'b1;
        found_hit  = 1'b1;
      end
      if (is_active[i] && (!found_act || age_q[i] > best_age)) begin
        act_sel    = '0;
        act_sel[i] = 1'b1;
        found_act  = 1'b1;
        best_age   = age_q[i];
      end
    end
  end

  always_comb begin
    tgt_sel = '0;
    if (assign_en) begin
      if (found_free)     tgt_sel = free_sel;
      else if (found_rel) tgt_sel = rel_sel;
      else                tgt_sel = act_sel;
    end
  end

  assign off_sel    = off_acc ? hit_sel : '0;
  assign steal_next = |(tgt_sel & ~is_free);

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    vstate_t              state_reg;
    logic [AGE_W-1:0]     age_reg;
    logic [NOTE_BITS-1:0] note_reg;

    assign is_free[gi]   = (state_reg == V_FREE);
    assign is_active[gi] = (state_reg == V_ACTIVE);
    assign is_rel[gi]    = (state_reg == V_RELEASING);
    assign is_retrig[gi] = (state_reg == V_RETRIG);
    assign note_hit[gi]  = is_active[gi] && (note_reg == note_num);
    assign age_q[gi]     = age_reg;
    assign voice_en[gi]  = is_active[gi];
    assign voice_note[gi*NOTE_BITS +: NOTE_BITS] = note_reg;

    // Assignment takes precedence over a same-cycle voice_avail for this voice.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= V_FREE;
        age_reg   <= '0;
        note_reg  <= '0;
      end else if (tgt_sel[gi]) begin
        state_reg <= (state_reg == V_ACTIVE) ? V_RETRIG : V_ACTIVE;
        note_reg  <= note_num;
        age_reg   <= '0;
      end else begin
        case (state_reg)
          V_ACTIVE: begin
            if (off_sel[gi]) state_reg <= V_RELEASING;
            if (assign_en && age_reg != AGE_MAX) age_reg <= age_reg + 1'b1;
          end
          V_RELEASING: begin
            if (voice_avail[gi]) begin
              state_reg <= V_FREE;
              age_reg   <= '0;
            end
          end
          V_RETRIG: state_reg <= V_ACTIVE;
          default:  state_reg <= state_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) steal_reg <= 1'b0;
    else        steal_reg <= steal_next;
  end

  assign steal = steal_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural allocation model.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NB = 7;

  localparam int S_FREE   = 0;
  localparam int S_ACTIVE = 1;
  localparam int S_REL    = 2;
  localparam int S_RETRIG = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              note_valid = 1'b0;
  logic              note_on = 1'b0;
  logic [NB-1:0]     note_num = '0;
  logic              note_ready;
  logic [NV-1:0]     voice_en;
  logic [NV*NB-1:0]  voice_note;
  logic [NV-1:0]     voice_avail = '0;
  logic              steal;

  int checks = 0;
  int errors = 0;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .note_valid(note_valid),
    .note_on(note_on),
    .note_num(note_num),
    .note_ready(note_ready),
    .voice_en(voice_en),
    .voice_note(voice_note),
    .voice_avail(voice_avail),
    .steal(steal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each voice is a (state, note, age) record.
  int m_state [NV] = '{default: 0};
  int m_note  [NV] = '{default: 0};
  int m_age   [NV] = '{default: 0};
  bit m_steal = 1'b0;
  bit m_acc   = 1'b0;

  function automatic bit exp_ready();
    for (int i = 0; i < NV; i++) if (m_state[i] == S_RETRIG) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NV-1:0] exp_en();
    logic [NV-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = (m_state[i] == S_ACTIVE);
    return r;
  endfunction

  function automatic logic [NV*NB-1:0] exp_notes();
    logic [NV*NB-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*NB +: NB] = NB'(m_note[i]);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int ns [NV];
    int nn [NV];
    int na [NV];
    int t;
    int best;
    bit dup;
    bit acc;
    bit nst;
    if (!rst_n) begin
      m_state <= '{default: S_FREE};
      m_note  <= '{default: 0};
      m_age   <= '{default: 0};
      m_steal <= 1'b0;
      m_acc   <= 1'b0;
    end else begin
      ns  = m_state;
      nn  = m_note;
      na  = m_age;
      nst = 1'b0;
      acc = note_valid && exp_ready();
      for (int i = 0; i < NV; i++) begin
        if (m_state[i] == S_RETRIG) ns[i] = S_ACTIVE;
        if (m_state[i] == S_REL && voice_avail[i]) begin
          ns[i] = S_FREE;
          na[i] = 0;
        end
      end
      if (acc && note_on) begin
        dup = 1'b0;
        for (int i = 0; i < NV; i++)
          if (m_state[i] == S_ACTIVE && m_note[i] == int'(note_num)) dup = 1'b1;
        if (!dup) begin
          t = -1;
          for (int i = 0; i < NV; i++) if (t < 0 && m_state[i] == S_FREE) t = i;
          for (int i = 0; i < NV; i++) if (t < 0 && m_state[i] == S_REL) t = i;
          if (t < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++)
              if (m_state[i] == S_ACTIVE && m_age[i] > best) begin
                t = i;
                best = m_age[i];
              end
          end
          if (t >= 0) begin
            for (int j = 0; j < NV; j++)
              if (j != t && m_state[j] == S_ACTIVE && m_age[j] < NV - 1) na[j] = m_age[j] + 1;
            ns[t] = (m_state[t] == S_ACTIVE) ? S_RETRIG : S_ACTIVE;
            nn[t] = int'(note_num);
            na[t] = 0;
            nst   = (m_state[t] != S_FREE);
          end
        end
      end else if (acc) begin
        t = -1;
        for (int i = 0; i < NV; i++)
          if (t < 0 && m_state[i] == S_ACTIVE && m_note[i] == int'(note_num)) t = i;
        if (t >= 0) ns[t] = S_REL;
      end
      m_state <= ns;
      m_note  <= nn;
      m_age   <= na;
      m_steal <= nst;
      m_acc   <= acc;
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("voice_en", 64'(voice_en), 64'(exp_en()));
    chk("voice_note", 64'(voice_note), 64'(exp_notes()));
    chk("note_ready", 64'(note_ready), 64'(exp_ready()));
    chk("steal", 64'(steal), 64'(m_steal));
  end

  task automatic step(input bit v, input bit on, input int num, input logic [NV-1:0] av);
    note_valid  = v;
    note_on     = on;
    note_num    = NB'(num);
    voice_avail = av;
    @(posedge clk);
    #1;
    $display("step valid=%0d on=%0d num=%0d avail=%b -> en=%b steal=%0d ready=%0d",
             v, on, num, av, voice_en, steal, note_ready);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"}, 64'(voice_en), 64'(0));
    chk({tag, "_note"}, 64'(voice_note), 64'(0));
    chk({tag, "_ready"}, 64'(note_ready), 64'(1));
    chk({tag, "_steal"}, 64'(steal), 64'(0));
  endtask

  initial begin
    // Event already pending while in reset: accepted on first edge after release.
    note_valid = 1'b1;
    note_on    = 1'b1;
    note_num   = NB'(60);
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("rst");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_en", 64'(voice_en), 64'(4'b0001));
    chk("first_note0", 64'(voice_note[NB-1:0]), 64'(60));

    step(1, 1, 62, '0);
    step(1, 1, 64, '0);
    chk("three_en", 64'(voice_en), 64'(4'b0111));
    chk("three_notes", 64'(voice_note[3*NB-1:0]), 64'({7'd64, 7'd62, 7'd60}));
    step(1, 1, 65, '0);
    chk("four_en", 64'(voice_en), 64'(4'b1111));

    step(1, 1, 67, '0);
    chk("retrig_steal", 64'(steal), 64'(1));
    chk("retrig_en", 64'(voice_en), 64'(4'b1110));
    chk("retrig_ready", 64'(note_ready), 64'(0));
    step(0, 0, 0, '0);
    chk("after_retrig_en", 64'(voice_en), 64'(4'b1111));
    chk("after_retrig_note0", 64'(voice_note[NB-1:0]), 64'(67));

    step(1, 0, 62, '0);
    chk("off62_en", 64'(voice_en), 64'(4'b1101));
    step(0, 0, 0, 4'b0010);
    step(1, 1, 70, '0);
    chk("reuse_en", 64'(voice_en), 64'(4'b1111));
    chk("reuse_steal", 64'(steal), 64'(0));
    chk("reuse_note1", 64'(voice_note[2*NB-1:NB]), 64'(70));

    step(1, 0, 99, '0);
    step(1, 1, 67, '0);
    chk("dup_steal", 64'(steal), 64'(0));
    step(0, 0, 0, 4'b0001);
    chk("noeffect_en", 64'(voice_en), 64'(4'b1111));
    chk("noeffect_notes", 64'(voice_note), 64'({7'd65, 7'd64, 7'd70, 7'd67}));

    step(1, 0, 67, '0);
    step(1, 0, 70, '0);
    step(1, 0, 64, '0);
    step(1, 0, 65, '0);
    chk("allrel_en", 64'(voice_en), 64'(4'b0000));
    step(1, 1, 72, '0);
    chk("relsteal_en", 64'(voice_en), 64'(4'b0001));
    chk("relsteal_steal", 64'(steal), 64'(1));
    chk("relsteal_ready", 64'(note_ready), 64'(1));
    chk("relsteal_note0", 64'(voice_note[NB-1:0]), 64'(72));

    step(1, 1, 73, '0);
    step(1, 1, 74, '0);
    step(1, 1, 75, '0);
    step(1, 1, 76, '0);
    chk("mid_retrig_en", 64'(voice_en), 64'(4'b1110));
    note_num = NB'(80);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_en", 64'(voice_en), 64'(4'b0001));
    chk("resume_note0", 64'(voice_note[NB-1:0]), 64'(80));
    step(0, 0, 0, '0);
    chk("resume_hold_en", 64'(voice_en), 64'(4'b0001));

    // Randomized traffic; unaccepted events are held by the source.
    for (int k = 0; k < 3000; k++) begin
      if (!(note_valid && !m_acc)) begin
        note_valid = ($urandom_range(0, 3) != 0);
        note_on    = ($urandom_range(0, 2) != 0);
        note_num   = NB'(60 + $urandom_range(0, 7));
      end
      for (int i = 0; i < NV; i++) voice_avail[i] = ($urandom_range(0, 2) == 0);
      if (k % 700 == 350) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
